mmio_port_responder: RTL and testbench



---
 rtl/mmio_pkg.sv | 22 ++
 rtl/mmio_timer.sv | 69 ++++++
 rtl/mmio_port_responder.sv | 128 ++++++++++++
 tb/tb_mmio_port_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port responder: register indices, CTRL bit
// positions and the timer state encoding.
package mmio_pkg;

  localparam logic [2:0] REG_PORT_OUT  = 3'd0;
  localparam logic [2:0] REG_PORT_IN   = 3'd1;
  localparam logic [2:0] REG_EDGE      = 3'd2;
  localparam logic [2:0] REG_TMR_LOAD  = 3'd3;
  localparam logic [2:0] REG_TMR_COUNT = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd6;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;
  localparam int EXP_BIT  = 2;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with optional auto-reload and a sticky expiry flag.
// The IDLE/RUN state doubles as the CTRL.EN bit seen by software.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctrl_write,
  input  logic                   ctrl_en,
  input  logic                   auto_reload,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   exp_clear,
  output logic [TIMER_WIDTH-1:0] count,
  output logic                   exp,
  output logic                   running
);

  tmr_state_e             state_q, state_d;
  logic [TIMER_WIDTH-1:0] count_d;
  logic                   exp_set;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count;
    exp_set = 1'b0;
    case (state_q)
      TMR_IDLE: begin
        if (ctrl_write && ctrl_en) begin
          state_d = TMR_RUN;
          count_d = load_value;
        end
      end
      TMR_RUN: begin
        // An explicit stop takes priority over an expiry on the same edge.
        if (ctrl_write && !ctrl_en) begin
          state_d = TMR_IDLE;
        end else if (count == '0) begin
          exp_set = 1'b1;
          if (auto_reload) count_d = load_value;
          else             state_d = TMR_IDLE;
        end else begin
          count_d = count - TIMER_WIDTH'(1);
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TMR_IDLE;
      count   <= '0;
      exp     <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      exp     <= exp_set | (exp & ~exp_clear);
    end
  end

  assign running = (state_q == TMR_RUN);

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped output port, synchronized input port with sticky edge capture,
// and a timer. Optional interrupt output enabled by MMIO_RESPONDER_IRQ_EN.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          IN_WIDTH    = 8,
  parameter int          TIMER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                Hit,
  output logic [31:0]         PortOut
`ifdef MMIO_RESPONDER_IRQ_EN
  ,
  output logic                Irq
`endif
);

  logic [2:0] idx;
  logic       wr_en;
  logic       unused_addr_bits;

  assign Hit              = (Address[31:5] == BASE_ADDR[31:5]);
  assign idx              = Address[4:2];
  assign wr_en            = MemWrite & Hit;
  assign unused_addr_bits = ^Address[1:0];

  logic wr_port_out, wr_edge, wr_load, wr_ctrl;
  assign wr_port_out = wr_en && (idx == REG_PORT_OUT);
  assign wr_edge     = wr_en && (idx == REG_EDGE);
  assign wr_load     = wr_en && (idx == REG_TMR_LOAD);
  assign wr_ctrl     = wr_en && (idx == REG_CTRL);

  logic [IN_WIDTH-1:0]    sync1, sync2, sync3, edge_flags, rise, edge_clear;
  logic [TIMER_WIDTH-1:0] tmr_load, tmr_count;
  logic                   tmr_auto, tmr_exp, tmr_running;

  assign rise       = sync2 & ~sync3;
  assign edge_clear = wr_edge ? WriteData[IN_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut    <= '0;
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      edge_flags <= '0;
      tmr_load   <= '0;
      tmr_auto   <= 1'b0;
    end else begin
      sync1      <= PortIn;
      sync2      <= sync1;
      sync3      <= sync2;
      // A new edge overrides a simultaneous write-1-to-clear of the same bit.
      edge_flags <= (edge_flags & ~edge_clear) | rise;
      if (wr_port_out) PortOut  <= WriteData;
      if (wr_load)     tmr_load <= WriteData[TIMER_WIDTH-1:0];
      if (wr_ctrl)     tmr_auto <= WriteData[AUTO_BIT];
    end
  end

  mmio_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .ctrl_write (wr_ctrl),
    .ctrl_en    (WriteData[EN_BIT]),
    .auto_reload(tmr_auto),
    .load_value (tmr_load),
    .exp_clear  (wr_ctrl & WriteData[EXP_BIT]),
    .count      (tmr_count),
    .exp        (tmr_exp),
    .running    (tmr_running)
  );

`ifdef MMIO_RESPONDER_IRQ_EN
  localparam logic [31:0] MASK_BITS =
    32'h8000_0000 | 32'((64'd1 << IN_WIDTH) - 64'd1);

  logic [31:0] irq_mask;
  logic        wr_mask;
  assign wr_mask = wr_en && (idx == REG_IRQ_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      Irq      <= 1'b0;
    end else begin
      if (wr_mask) irq_mask <= WriteData & MASK_BITS;
      Irq <= (|(edge_flags & irq_mask[IN_WIDTH-1:0])) | (tmr_exp & irq_mask[31]);
    end
  end
`endif

  // Zero-latency read mux so single-cycle loads complete in the same cycle.
  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (idx)
        REG_PORT_OUT:  ReadData = PortOut;
        REG_PORT_IN:   ReadData = 32'(sync2);
        REG_EDGE:      ReadData = 32'(edge_flags);
        REG_TMR_LOAD:  ReadData = 32'(tmr_load);
        REG_TMR_COUNT: ReadData = 32'(tmr_count);
        REG_CTRL: begin
          ReadData[EN_BIT]   = tmr_running;
          ReadData[AUTO_BIT] = tmr_auto;
          ReadData[EXP_BIT]  = tmr_exp;
        end
        REG_IRQ_MASK: begin
`ifdef MMIO_RESPONDER_IRQ_EN
          ReadData = irq_mask;
`endif
        end
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: directed scenarios plus random
// bus traffic checked against a register-level reference model.
`timescale 1ns/1ps
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
`ifdef MMIO_RESPONDER_IRQ_EN
  logic        Irq;
`endif

  always #5 clk = ~clk;

  mmio_port_responder dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Address  (Address),
    .WriteData(WriteData),
    .PortIn   (PortIn),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortOut  (PortOut)
`ifdef MMIO_RESPONDER_IRQ_EN
    ,
    .Irq      (Irq)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        hit;
  } rd_exp_t;
  rd_exp_t sb[$];

  // Reference model: register contents as software sees them.
  logic [31:0] m_port_out = '0, m_load = '0, m_count = '0, m_mask = '0;
  logic [7:0]  m_s1 = '0, m_s2 = '0, m_s3 = '0, m_edge = '0;
  logic        m_run = 1'b0, m_auto = 1'b0, m_exp = 1'b0, m_irq = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic logic addr_hit(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return a[31:5] == b[31:5];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!addr_hit(a)) return '0;
    case (a[4:2])
      3'd0: return m_port_out;
      3'd1: return {24'd0, m_s2};
      3'd2: return {24'd0, m_edge};
      3'd3: return m_load;
      3'd4: return m_count;
      3'd5: return {29'd0, m_exp, m_auto, m_run};
`ifdef MMIO_RESPONDER_IRQ_EN
      3'd6: return m_mask;
`endif
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic       wr, ctrl_wr, exp_set, t_run;
    logic [2:0] wi;
    logic [31:0] t_cnt;
    logic [7:0]  clr;
    if (reset) begin
      m_port_out <= '0; m_load <= '0; m_count <= '0; m_mask <= '0;
      m_s1 <= '0; m_s2 <= '0; m_s3 <= '0; m_edge <= '0;
      m_run <= 1'b0; m_auto <= 1'b0; m_exp <= 1'b0; m_irq <= 1'b0;
    end else begin
      wr      = MemWrite && addr_hit(Address);
      wi      = Address[4:2];
      ctrl_wr = wr && (wi == 3'd5);
      clr     = (wr && wi == 3'd2) ? WriteData[7:0] : 8'h00;
      t_run   = m_run;
      t_cnt   = m_count;
      exp_set = 1'b0;
      if (m_run) begin
        if (ctrl_wr && !WriteData[0]) t_run = 1'b0;
        else if (m_count == 0) begin
          exp_set = 1'b1;
          if (m_auto) t_cnt = m_load;
          else        t_run = 1'b0;
        end else t_cnt = m_count - 1;
      end else if (ctrl_wr && WriteData[0]) begin
        t_run = 1'b1;
        t_cnt = m_load;
      end
      m_run   <= t_run;
      m_count <= t_cnt;
      m_exp   <= exp_set | (m_exp & !(ctrl_wr && WriteData[2]));
      m_irq   <= (|(m_edge & m_mask[7:0])) | (m_exp & m_mask[31]);
      m_edge  <= (m_edge & ~clr) | (m_s2 & ~m_s3);
      m_s1 <= PortIn; m_s2 <= m_s1; m_s3 <= m_s2;
      if (wr && wi == 3'd0) m_port_out <= WriteData;
      if (wr && wi == 3'd3) m_load <= WriteData;
      if (ctrl_wr)          m_auto <= WriteData[1];
      if (wr && wi == 3'd6) m_mask <= WriteData & 32'h8000_00FF;
    end
  end

  // Monitor: pops the scoreboard whenever a load is presented.
  always @(negedge clk) begin
    rd_exp_t e;
    if (checking) begin
      check("port_out", {32'd0, PortOut}, {32'd0, m_port_out});
`ifdef MMIO_RESPONDER_IRQ_EN
      check("irq", {63'd0, Irq}, {63'd0, m_irq});
`endif
      if (MemRead) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_underflow: got a load at %h, want a queued expectation", Address);
        end else begin
          e = sb.pop_front();
          check($sformatf("read@%h {hit,data}", e.addr), {31'd0, Hit, ReadData},
                {31'd0, e.hit, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Address = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    sb.push_back('{addr: a, data: model_read(a), hit: addr_hit(a)});
    MemRead = 1'b1; Address = a;
    tick();
    MemRead = 1'b0;
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] v);
    sb.push_back('{addr: a, data: v, hit: addr_hit(a)});
    MemRead = 1'b1; Address = a;
    tick();
    MemRead = 1'b0;
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{addr: a, data: model_read(a), hit: addr_hit(a)});
    MemRead = 1'b1; MemWrite = 1'b1; Address = a; WriteData = d;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  localparam logic [31:0] A_OUT = BASE + 32'h00, A_IN = BASE + 32'h04,
                          A_EDGE = BASE + 32'h08, A_LOAD = BASE + 32'h0C,
                          A_CNT = BASE + 32'h10, A_CTRL = BASE + 32'h14;

  initial begin
    tick(); tick();
    reset = 1'b0;
    checking = 1'b1;

    for (int i = 0; i < 8; i++) rd_exp(BASE + 32'(i * 4), 32'h0);

    wr(A_OUT, 32'hA5A5_0001);
    check("port_out_after_store", {32'd0, PortOut}, {32'd0, 32'hA5A5_0001});
    rd_exp(A_OUT, 32'hA5A5_0001);
    rd_exp(BASE + 32'h40, 32'h0);
    rw(A_OUT, 32'h1234_5678);
    rd_exp(A_OUT + 32'h3, 32'h1234_5678);
    wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    rd_exp(BASE + 32'h1C, 32'h0);
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    rd(BASE + 32'h18);

    PortIn = 8'h81;
    tick();
    rd_exp(A_EDGE, 32'h0);
    rd_exp(A_IN, 32'h81);
    rd_exp(A_EDGE, 32'h81);
    wr(A_EDGE, 32'h1);
    rd_exp(A_EDGE, 32'h80);

    PortIn = 8'h80;
    tick(); tick(); tick();
    PortIn = 8'h81;
    tick(); tick();
    wr(A_EDGE, 32'h1);
    rd_exp(A_EDGE, 32'h81);
    wr(A_EDGE, 32'hFF);
    rd_exp(A_EDGE, 32'h0);

    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h1);
    rd_exp(A_CNT, 32'd3); rd_exp(A_CNT, 32'd2); rd_exp(A_CNT, 32'd1); rd_exp(A_CNT, 32'd0);
    rd_exp(A_CTRL, 32'h4);
    rd_exp(A_CNT, 32'd0);
    wr(A_CTRL, 32'h4);
    rd_exp(A_CTRL, 32'h0);

    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h3);
    rd_exp(A_CNT, 32'd2); rd_exp(A_CNT, 32'd1); rd_exp(A_CNT, 32'd0);
    rd_exp(A_CNT, 32'd2); rd_exp(A_CNT, 32'd1); rd_exp(A_CNT, 32'd0);
    rd_exp(A_CTRL, 32'h7);
    wr(A_LOAD, 32'd5);
    rd_exp(A_CNT, 32'd0);
    rd_exp(A_CNT, 32'd5);
    rd_exp(A_CNT, 32'd4);
    wr(A_CTRL, 32'h3);
    rd_exp(A_CNT, 32'd2);
    tick();
    wr(A_CTRL, 32'h7);
    rd_exp(A_CTRL, 32'h7);
    rd_exp(A_CNT, 32'd4);

    wr(A_CTRL, 32'h4);
    wr(A_LOAD, 32'd9);
    wr(A_CTRL, 32'h1);
    tick(); tick();
    rd_exp(A_CNT, 32'd7);
    wr(A_CTRL, 32'h0);
    rd_exp(A_CNT, 32'd6);
    rd_exp(A_CNT, 32'd6);
    rd_exp(A_CTRL, 32'h0);

    wr(A_CTRL, 32'h1);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("port_out_after_reset", {32'd0, PortOut}, 64'd0);
`ifdef MMIO_RESPONDER_IRQ_EN
    check("irq_after_reset", {63'd0, Irq}, 64'd0);
`endif
    rd_exp(A_CNT, 32'd0);
    rd_exp(A_CTRL, 32'h0);

    for (int i = 0; i < 600; i++) begin
      int          op;
      logic [2:0]  ri;
      logic [31:0] a, d;
      if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom);
      ri = 3'($urandom_range(0, 7));
      a  = BASE + {27'd0, ri, 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a + 32'h20 * 32'($urandom_range(1, 4));
      op = $urandom_range(0, 7);
      case (ri)
        3'd3:    d = 32'($urandom_range(0, 6));
        3'd5:    d = 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      if (op <= 3)      rd(a);
      else if (op <= 5) wr(a, d);
      else if (op == 6) tick();
      else              rw(a, d);
    end

    tick(); tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
